// File: rtl/gate_selftest_ctrl.sv
// rtl/gate_selftest_ctrl.sv - sweeps a/b over the four input vectors and checks the gate unit against its truth table
module gate_selftest_ctrl #(
    parameter int SETTLE = 1,
    parameter int LOOPS  = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic       o_gate_a,
    output logic       o_gate_b,
    input  logic [6:0] i_gate_y,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_pass,
    output logic [3:0] o_err_cnt,
    output logic [3:0] o_fail_vec,
    output logic [6:0] o_last_y
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);
    localparam logic [3:0] LAST_LOOP = 4'(LOOPS - 1);

    state_t     r_state;
    logic [1:0] r_idx;
    logic [3:0] r_loop;
    logic [3:0] r_cnt;
    logic       r_gate_a;
    logic       r_gate_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_err_cnt;
    logic [3:0] r_fail_vec;
    logic [6:0] r_last_y;

    logic [6:0] w_golden;
    logic       w_mismatch;
    logic       w_sample;
    logic       w_last_vec;
    logic [3:0] w_err_next;

    always_comb begin
        w_golden = 7'h1D;
        case (r_idx)
            2'd0: w_golden = 7'h1D;
            2'd1: w_golden = 7'h2A;
            2'd2: w_golden = 7'h3A;
            2'd3: w_golden = 7'h61;
            default: w_golden = 7'h1D;
        endcase
    end

    // Case inequality so an X/Z bit from the gate unit is reported, not masked.
    assign w_mismatch = (i_gate_y !== w_golden);
    assign w_sample   = (r_cnt == 4'd1);
    assign w_last_vec = (r_idx == 2'd3) && (r_loop == LAST_LOOP);
    assign w_err_next = (w_mismatch && (r_err_cnt != 4'hF)) ? r_err_cnt + 4'd1 : r_err_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_idx      <= 2'd0;
            r_loop     <= 4'd0;
            r_cnt      <= 4'd0;
            r_gate_a   <= 1'b0;
            r_gate_b   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= 4'd0;
            r_fail_vec <= 4'd0;
            r_last_y   <= 7'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_RUN;
                        r_busy     <= 1'b1;
                        r_idx      <= 2'd0;
                        r_loop     <= 4'd0;
                        r_cnt      <= SETTLE_L;
                        r_gate_a   <= 1'b0;
                        r_gate_b   <= 1'b0;
                        r_err_cnt  <= 4'd0;
                        r_fail_vec <= 4'd0;
                        r_pass     <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_sample) begin
                        r_last_y  <= i_gate_y;
                        r_err_cnt <= w_err_next;
                        if (w_mismatch) begin
                            r_fail_vec[r_idx] <= 1'b1;
                        end
                        r_cnt <= SETTLE_L;
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_loop <= r_loop + 4'd1;
                        end
                        {r_gate_a, r_gate_b} <= r_idx + 2'd1;
                        // Pass uses the post-sample count so the final vector is included.
                        if (w_last_vec) begin
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_gate_a <= 1'b0;
                            r_gate_b <= 1'b0;
                            r_pass   <= (w_err_next == 4'd0);
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_gate_a   = r_gate_a;
    assign o_gate_b   = r_gate_b;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_pass     = r_pass;
    assign o_err_cnt  = r_err_cnt;
    assign o_fail_vec = r_fail_vec;
    assign o_last_y   = r_last_y;

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// tb/tb_gate_selftest_ctrl.sv - directed vector bench for gate_selftest_ctrl
module tb_gate_selftest_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [1:0]      fault_mode;
    logic [2:0]      start_v;
    logic [2:0]      a_v;
    logic [2:0]      b_v;
    logic [2:0]      busy_v;
    logic [2:0]      done_v;
    logic [2:0]      pass_v;
    logic [2:0][6:0] y_v;
    logic [2:0][6:0] ly_v;
    logic [2:0][3:0] err_v;
    logic [2:0][3:0] fv_v;

    int n_cmp = 0;
    int n_fail = 0;

    // 0: healthy, 1: xor stuck at 0, 2: all outputs 0, 3: bit 4 X on a=1,b=0
    function automatic logic [6:0] gate_model(input logic a, input logic b, input logic [1:0] m);
        logic [6:0] y;
        y = {a & b, a | b, ~b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
        if (m == 2'd1) y[1] = 1'b0;
        if (m == 2'd2) y = 7'd0;
        if (m == 2'd3 && a && !b) y[4] = 1'bx;
        return y;
    endfunction

    assign y_v[0] = gate_model(a_v[0], b_v[0], fault_mode);
    assign y_v[1] = gate_model(a_v[1], b_v[1], fault_mode);
    assign y_v[2] = gate_model(a_v[2], b_v[2], fault_mode);

    gate_selftest_ctrl u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start_v[0]),
        .o_gate_a(a_v[0]), .o_gate_b(b_v[0]), .i_gate_y(y_v[0]),
        .o_busy(busy_v[0]), .o_done(done_v[0]), .o_pass(pass_v[0]),
        .o_err_cnt(err_v[0]), .o_fail_vec(fv_v[0]), .o_last_y(ly_v[0])
    );

    gate_selftest_ctrl #(.SETTLE(3), .LOOPS(2)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start_v[1]),
        .o_gate_a(a_v[1]), .o_gate_b(b_v[1]), .i_gate_y(y_v[1]),
        .o_busy(busy_v[1]), .o_done(done_v[1]), .o_pass(pass_v[1]),
        .o_err_cnt(err_v[1]), .o_fail_vec(fv_v[1]), .o_last_y(ly_v[1])
    );

    gate_selftest_ctrl #(.LOOPS(5)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start_v[2]),
        .o_gate_a(a_v[2]), .o_gate_b(b_v[2]), .i_gate_y(y_v[2]),
        .o_busy(busy_v[2]), .o_done(done_v[2]), .o_pass(pass_v[2]),
        .o_err_cnt(err_v[2]), .o_fail_vec(fv_v[2]), .o_last_y(ly_v[2])
    );

    typedef struct {
        int         dut;
        logic [1:0] fault;
        int         lat;
        logic       pass;
        logic [3:0] err;
        logic [3:0] fv;
        logic [6:0] ly;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] all_outs(input int d);
        return {9'd0, busy_v[d], done_v[d], pass_v[d], err_v[d], fv_v[d], ly_v[d], a_v[d], b_v[d]};
    endfunction

    task automatic apply(input vec_t v);
        int lat;
        fault_mode = v.fault;
        @(negedge clk);
        start_v[v.dut] = 1'b1;
        @(negedge clk);
        start_v[v.dut] = 1'b0;
        chk("busy_on", busy_v[v.dut], 1);
        chk("err_clear", err_v[v.dut], 0);
        lat = 0;
        while (!done_v[v.dut] && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, v.lat);
        chk("busy_off", busy_v[v.dut], 0);
        chk("pass", pass_v[v.dut], v.pass);
        chk("err_cnt", err_v[v.dut], v.err);
        chk("fail_vec", fv_v[v.dut], v.fv);
        chk("last_y", ly_v[v.dut], v.ly);
        @(negedge clk);
        chk("done_one_cycle", done_v[v.dut], 0);
        chk("pass_hold", pass_v[v.dut], v.pass);
    endtask

    initial begin
        vec_t       tbl[9];
        logic [6:0] gold[4];
        int         dcnt;
        int         first_done;

        tbl[0] = '{0, 2'd0, 4,  1'b1, 4'h0, 4'h0, 7'h61};
        tbl[1] = '{0, 2'd1, 4,  1'b0, 4'h2, 4'h6, 7'h61};
        tbl[2] = '{0, 2'd2, 4,  1'b0, 4'h4, 4'hF, 7'h00};
        tbl[3] = '{0, 2'd3, 4,  1'b0, 4'h1, 4'h4, 7'h61};
        tbl[4] = '{0, 2'd0, 4,  1'b1, 4'h0, 4'h0, 7'h61};
        tbl[5] = '{1, 2'd0, 24, 1'b1, 4'h0, 4'h0, 7'h61};
        tbl[6] = '{1, 2'd1, 24, 1'b0, 4'h4, 4'h6, 7'h61};
        tbl[7] = '{2, 2'd2, 20, 1'b0, 4'hF, 4'hF, 7'h00};
        tbl[8] = '{2, 2'd0, 20, 1'b1, 4'h0, 4'h0, 7'h61};
        gold[0] = 7'h1D;
        gold[1] = 7'h2A;
        gold[2] = 7'h3A;
        gold[3] = 7'h61;

        rst = 1'b1;
        start_v = 3'b000;
        fault_mode = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) chk("reset_state", all_outs(d), 0);

        for (int i = 0; i < 9; i++) apply(tbl[i]);

        // Sample order and driven vectors on the default instance.
        fault_mode = 2'd0;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("seq_ab0", {a_v[0], b_v[0]}, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("seq_last_y", ly_v[0], gold[k-1]);
            if (k < 4) chk("seq_ab", {a_v[0], b_v[0]}, k);
            else       chk("seq_done", done_v[0], 1);
        end
        @(negedge clk);

        // Start held through the run and the DONE cycle: one run only.
        @(negedge clk);
        start_v[0] = 1'b1;
        dcnt = 0;
        first_done = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (done_v[0]) begin
                dcnt++;
                if (first_done == 0) first_done = i;
            end
            if (i == 6) start_v[0] = 1'b0;
        end
        chk("held_done_count", dcnt, 1);
        chk("held_done_time", first_done, 5);
        chk("held_busy_end", busy_v[0], 0);

        // Reset two cycles into a run.
        fault_mode = 2'd2;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        chk("pre_reset_err", err_v[0], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_reset_outs", all_outs(0), 0);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done_v[0]) dcnt++;
        end
        chk("reset_no_done", dcnt, 0);
        chk("reset_idle_busy", busy_v[0], 0);

        apply(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_selftest_ctrl.md
# gate_selftest_ctrl

Sequencer and self-checker for the 7-output two-input gate unit (y[6:0] = and, or, not_b, nand, nor, xor, xnor). On a start request it drives the unit's a/b inputs through all four vectors, waits a programmable settle time, samples y, and compares it against the golden truth table. It reports pass/fail, a saturating error count and a per-vector failure mask. It sits between the gate unit and any built-in-self-test or bring-up logic.

## Interface
- SETTLE, default 1: cycles each vector is held before sampling; legal 1..15.
- LOOPS, default 1: number of full 4-vector sweeps per run; legal 1..15.

- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  run request; accepted only in IDLE.
- gate_a  output  1  drives gate unit input a.
- gate_b  output  1  drives gate unit input b.
- gate_y  input  7  gate unit output, bit order as above.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse at run completion.
- pass  output  1  1 if the last completed run had zero mismatches; held until next accepted start.
- err_cnt  output  4  mismatching samples in current/last run, saturates at 15.
- fail_vec  output  4  bit i set if vector i ({a,b}=i) mismatched in any loop.
- last_y  output  7  most recent sampled gate_y.

## Operation
- Vector order per sweep: idx 0..3, {gate_a,gate_b} = idx (00, 01, 10, 11).
- Golden y per idx: 0 -> 7'h1D, 1 -> 7'h2A, 2 -> 7'h3A, 3 -> 7'h61.
- Mismatch: any bit of gate_y differs from golden; X or Z on any gate_y bit counts as a mismatch (compare with case inequality in sim; synthesized logic treats it as a plain inequality).
- FSM states: IDLE, RUN, DONE.
  - IDLE: gate_a = gate_b = 0, busy = 0. start=1 -> RUN. On acceptance, clear err_cnt, fail_vec and pass; load idx=0, loop=0, settle counter=SETTLE.
  - RUN: drive current idx. The settle counter decrements each cycle. At the edge where the counter reaches its final cycle:
    - sample gate_y into last_y;
    - on mismatch, increment err_cnt (saturating at 15) and set fail_vec[idx];
    - advance idx, wrapping 3 -> 0 and incrementing loop;
    - reload the counter.
    - After the last sample of the final loop -> DONE.
  - DONE: one cycle. done=1, busy=0, gate_a/b=0, and pass = (err_cnt==0), including the final sample. Then -> IDLE.
- start while busy, or during the DONE cycle, is ignored (no queuing).
- Results (pass, err_cnt, fail_vec, last_y) hold after DONE until the next accepted start.

## Timing
- Reset: state IDLE; gate_a, gate_b, busy, done, pass = 0; err_cnt = 0; fail_vec = 0; last_y = 0.
- Reset mid-run aborts immediately, with no done pulse and all outputs at reset values next cycle.
- Start sampled high at edge E0 (in IDLE): from E0, busy=1 and vector 0 is driven.
- Each vector is held exactly SETTLE cycles. gate_y is sampled at edges E0+k·SETTLE for k = 1..4·LOOPS, and the next vector is applied at that same edge.
- Final sample at E0+4·LOOPS·SETTLE. At that edge, busy falls, done rises for one cycle, and pass/err_cnt/fail_vec are final.
- The earliest next accepted start is the edge ending the DONE cycle + 1, i.e. the first IDLE cycle.
- The gate unit is combinational. With SETTLE=1, gate_y must be valid within the cycle the vector is driven.

## Test plan
- Defaults, correct gate model, pulse start: busy high 4 cycles; sample sequence 1D, 2A, 3A, 61; done pulse 4 cycles after start edge; pass=1, err_cnt=0, fail_vec=0000, last_y=7'h61.
- Fault injection, y[1] (xor) stuck at 0: vectors 01 and 10 mismatch; err_cnt=2, fail_vec=4'b0110, pass=0.
- SETTLE=3, LOOPS=2, correct model: each vector held 3 cycles; order 00, 01, 10, 11 twice; done exactly 24 cycles after start; pass=1.
- LOOPS=5, gate_y forced 0: 20 mismatches; err_cnt saturates at 15; fail_vec=1111; pass=0.
- gate_y bit 4 driven X on vector 2 only: counted as mismatch; err_cnt=1, fail_vec=0100.
- Control corner cases:
  - start held high throughout a run: exactly one run, no extra done.
  - rst asserted at cycle 2 of a run: no done, all outputs 0 next cycle.
  - A fresh start after reset runs normally.
